store_narrow_unit: RTL
======================

Name: store_narrow_unit

Overview:
- Store-side counterpart of the load-path sign extender: takes a 32-bit register value plus an access size and narrows it to a byte or halfword memory write.
- Produces a word-aligned address, lane-replicated write data and byte enables.
- Sits between the EX/MEM stage store port and the data-memory write port.
- Carries a 2-entry elastic buffer with valid/ready on both sides, and detects misaligned stores.

Parameters:
- ADDR_W, 32, address width in bits.
- DEPTH, 2, buffer entries; legal values 2 or 4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  store request valid.
- req_ready  out  1  unit can accept a request.
- req_addr  in  ADDR_W  byte address.
- req_data  in  32  register value to store.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- mem_valid  out  1  memory write valid.
- mem_ready  in  1  memory accepts write.
- mem_addr  out  ADDR_W  word-aligned address; bits [1:0] always 0.
- mem_wdata  out  32  lane-replicated write data.
- mem_be  out  4  byte enables; be[3] = byte offset 0 (bits 31:24), big-endian.
- err_valid  out  1  one-cycle pulse on a rejected request.
- err_addr  out  ADDR_W  address of the rejected request.
- err_code  out  2  01 misaligned, 10 reserved size, 11 range (optional feature).

Behaviour:
- Reset values:
  - mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0.
  - err_valid=0, err_addr=0, err_code=0.
  - Buffer empty; req_ready=1 in the cycle after reset deasserts.
- Accept: request accepted on a clk edge with req_valid & req_ready.
  - req_ready = buffer not full. It is registered-free only on occupancy count, never on mem_ready combinationally.
- Formatting, done at accept and stored in the buffer:
  - byte: wdata = {4{data[7:0]}}; be = 1000 >> addr[1:0].
  - half: wdata = {2{data[15:0]}}; be = 1100 if addr[1]=0, else 0011.
  - word: wdata = data; be = 1111.
  - mem_addr = {req_addr[ADDR_W-1:2], 2'b00}.
- Rejects (nothing enqueued):
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Reserved size 11.
  - A reject drives err_valid=1 for exactly the cycle after accept, with err_addr=req_addr and the matching err_code. Misaligned takes priority over range.
- Latency: an accepted request reaches mem_valid the following cycle at the earliest. FIFO order is preserved.
- Output handshake:
  - Head entry presented while the buffer is non-empty.
  - Pops on mem_valid & mem_ready.
  - mem_addr, mem_wdata and mem_be hold stable while mem_valid=1 & mem_ready=0.
- Simultaneous push and pop when full: req_ready=0, so no push that cycle. When neither full nor empty, both occur and occupancy is unchanged.
- Full throughput: with mem_ready held at 1, one store per cycle is sustained.
- Pointers wrap modulo DEPTH. Occupancy counter width is clog2(DEPTH)+1.
- Reset mid-operation flushes all entries. No partially issued write survives. mem_valid is 0 the cycle after reset is sampled.

Optional Feature:
- Macro: STORE_RANGE_CHECK_EN.
- With the macro defined:
  - A byte store whose req_data differs from sign-extension of data[7:0] is rejected with err_code=11.
  - Likewise a half store whose req_data differs from sign-extension of data[15:0].
  - Rejected stores are not enqueued.
- Without the macro:
  - Truncation is silent.
  - err_code 11 is never produced.
  - No comparison logic is synthesized.

Test Plan:
- Byte store: addr 0x1003, data 0xFFFFFF5A -> mem_addr 0x1000, wdata 0x5A5A5A5A, be 0001, mem_valid one cycle after accept.
- Half store: addr 0x2002, data 0x0000BEEF, macro off -> wdata 0xBEEFBEEF, be 0011. With macro on -> err_valid, err_code 11, nothing issued.
- Misaligned word: addr 0x3001 -> err_valid pulse, err_addr 0x3001, err_code 01, mem_valid stays 0.
- Backpressure: mem_ready=0, push 3 requests (DEPTH=2) -> req_ready drops after 2. Raise mem_ready -> outputs drain in order, outputs stable while stalled.
- Streaming: 8 back-to-back word stores with mem_ready=1 -> 8 writes on 8 consecutive cycles, with no bubbles.
- Reset with 2 entries buffered -> mem_valid=0 and req_ready=1 next cycle; no stale write ever issued.

Source files
------------

// File: rtl/store_narrow_unit.sv
// store_narrow_unit
//   Narrows a 32-bit store value to a byte, halfword or word memory write.
//   It produces a word-aligned address, lane-replicated write data and big-endian
//   byte enables, and queues each store in a small elastic buffer. Misaligned
//   stores and reserved sizes are rejected with a one-cycle error pulse.
//
//   Optional feature: define STORE_RANGE_CHECK_EN to reject byte/half stores whose
//   value does not fit the narrowed size as a signed quantity (err_code 11).
//
// Ports
//   clk, reset             clock (rising edge), synchronous active-high reset
//   req_valid/req_ready    request handshake
//   req_addr/data/size     byte address, register value, size (00 B, 01 H, 10 W)
//   mem_valid/mem_ready    memory write handshake
//   mem_addr/wdata/be      word address, replicated data, byte enables (be[3]=offset 0)
//   err_valid/addr/code    reject pulse, offending address, 01 misalign/10 size/11 range
module store_narrow_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  output logic [1:0]        err_code
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [ADDR_W-1:0] r_addr  [DEPTH];
  logic [31:0]       r_wdata [DEPTH];
  logic [3:0]        r_be    [DEPTH];
  logic [PtrW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]   r_count;
  logic              r_err_valid;
  logic [ADDR_W-1:0] r_err_addr;
  logic [1:0]        r_err_code;

  logic        w_full, w_empty, w_accept, w_push, w_pop;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic [1:0]  w_err_code;

  assign w_full    = (r_count == FullCnt);
  assign w_empty   = (r_count == '0);
  assign req_ready = ~w_full;
  assign w_accept  = req_valid & req_ready;
  assign w_push    = w_accept & (w_err_code == 2'b00);
  assign mem_valid = ~w_empty;
  assign w_pop     = mem_valid & mem_ready;

  // Lane formatting.
  always_comb begin
    w_wdata = '0;
    w_be    = '0;
    unique case (req_size)
      2'b00: begin
        w_wdata = {4{req_data[7:0]}};
        w_be    = 4'b1000 >> req_addr[1:0];
      end
      2'b01: begin
        w_wdata = {2{req_data[15:0]}};
        w_be    = req_addr[1] ? 4'b0011 : 4'b1100;
      end
      2'b10: begin
        w_wdata = req_data;
        w_be    = 4'b1111;
      end
      default: ;
    endcase
  end

  // Reject classification; misalignment outranks the range check.
  always_comb begin
    w_err_code = 2'b00;
    if (req_size == 2'b11) begin
      w_err_code = 2'b10;
    end else if ((req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00)) begin
      w_err_code = 2'b01;
`ifdef STORE_RANGE_CHECK_EN
    end else if ((req_size == 2'b00 && req_data != {{24{req_data[7]}}, req_data[7:0]}) ||
                 (req_size == 2'b01 && req_data != {{16{req_data[15]}}, req_data[15:0]})) begin
      w_err_code = 2'b11;
`endif
    end
  end

  // Storage needs no reset: outputs are masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr]  <= {req_addr[ADDR_W-1:2], 2'b00};
      r_wdata[r_wr_ptr] <= w_wdata;
      r_be[r_wr_ptr]    <= w_be;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
      r_err_code  <= 2'b00;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_err_valid <= w_accept & ~w_push;
      if (w_accept & ~w_push) begin
        r_err_addr <= req_addr;
        r_err_code <= w_err_code;
      end
    end
  end

  assign mem_addr  = w_empty ? '0 : r_addr[r_rd_ptr];
  assign mem_wdata = w_empty ? '0 : r_wdata[r_rd_ptr];
  assign mem_be    = w_empty ? '0 : r_be[r_rd_ptr];
  assign err_valid = r_err_valid;
  assign err_addr  = r_err_addr;
  assign err_code  = r_err_code;

endmodule
